// File: rtl/oled_pkg.sv
// OLED init sequencer shared definitions.
// Command table, control bytes and FSM states.
package oled_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWR_WAIT,
    S_CMD,
    S_CLR,
    S_DISP_ON,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int         CMD_LEN     = 24;
  localparam logic [4:0] CMD_LAST    = 5'd23;
  localparam logic [7:0] CTRL_CMD    = 8'h00;
  localparam logic [7:0] CTRL_DATA   = 8'h40;
  localparam logic [7:0] DISP_ON_CMD = 8'hAF;
  localparam logic [7:0] SLAVE_ADDR  = 8'h7A;

  // SSD1306-style power-up command list.
  function automatic logic [7:0] cmd_byte(
    input logic [4:0] idx
  );
    logic [7:0] b;
    case (idx)
      5'd0:    b = 8'hAE;
      5'd1:    b = 8'hD5;
      5'd2:    b = 8'h80;
      5'd3:    b = 8'hA8;
      5'd4:    b = 8'h3F;
      5'd5:    b = 8'hD3;
      5'd6:    b = 8'h00;
      5'd7:    b = 8'h40;
      5'd8:    b = 8'h8D;
      5'd9:    b = 8'h14;
      5'd10:   b = 8'h20;
      5'd11:   b = 8'h00;
      5'd12:   b = 8'hA1;
      5'd13:   b = 8'hC8;
      5'd14:   b = 8'hDA;
      5'd15:   b = 8'h12;
      5'd16:   b = 8'h81;
      5'd17:   b = 8'hCF;
      5'd18:   b = 8'hD9;
      5'd19:   b = 8'hF1;
      5'd20:   b = 8'hDB;
      5'd21:   b = 8'h40;
      5'd22:   b = 8'hA4;
      5'd23:   b = 8'hA6;
      default: b = 8'hE3;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/oled_delay_cnt.sv
// Loadable down-counter with terminal flag.
// Shared by the power-up delay and the transaction timeout.
module oled_delay_cnt
  import oled_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins; otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/oled_init_seq.sv
// OLED power-up sequencer: delay, command list,
// GDDRAM clear and display-on over an I2C byte engine.
module oled_init_seq
  import oled_pkg::*;
#(
  parameter int PWR_DELAY = 1000,
  parameter int TIMEOUT   = 4096,
  parameter int CLR_BYTES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       tx_req,
  output logic [7:0] tx_dc,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic       ready,
  output logic       err
);

  localparam logic [15:0] PWR_LOAD =
    (PWR_DELAY > 0) ? 16'(PWR_DELAY - 1) : 16'd0;
  localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT - 1);
  localparam logic [10:0] CLR_LAST = 11'(CLR_BYTES - 1);

  state_e      state_q,   state_d;
  logic [4:0]  cmd_idx_q, cmd_idx_d;
  logic [10:0] clr_cnt_q, clr_cnt_d;
  logic        tx_req_q,  tx_req_d;
  logic [7:0]  tx_dc_q,   tx_dc_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic        dly_load;
  logic [15:0] dly_val;
  logic        dly_en;
  logic        dly_zero;

  logic [7:0]  cur_dc;
  logic [7:0]  cur_data;

  oled_delay_cnt #(
    .W(16)
  ) u_dly (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_val),
    .en       (dly_en),
    .zero     (dly_zero)
  );

  // Byte pair for the transaction of the current phase.
  always_comb begin
    cur_dc   = CTRL_CMD;
    cur_data = cmd_byte(cmd_idx_q);
    case (state_q)
      S_CLR: begin
        cur_dc   = CTRL_DATA;
        cur_data = 8'h00;
      end
      S_DISP_ON: begin
        cur_dc   = CTRL_CMD;
        cur_data = DISP_ON_CMD;
      end
      default: ;
    endcase
  end

  // Next-state, counters and request handshake.
  always_comb begin
    state_d   = state_q;
    cmd_idx_d = cmd_idx_q;
    clr_cnt_d = clr_cnt_q;
    tx_req_d  = tx_req_q;
    tx_dc_d   = tx_dc_q;
    tx_data_d = tx_data_q;
    dly_load  = 1'b0;
    dly_val   = TO_LOAD;
    dly_en    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          cmd_idx_d = '0;
          clr_cnt_d = '0;
          if (PWR_DELAY == 0) begin
            // Zero delay: first command goes out at once.
            state_d   = S_CMD;
            tx_req_d  = 1'b1;
            tx_dc_d   = CTRL_CMD;
            tx_data_d = cmd_byte(5'd0);
            dly_load  = 1'b1;
          end else begin
            state_d  = S_PWR_WAIT;
            dly_load = 1'b1;
            dly_val  = PWR_LOAD;
          end
        end
      end
      S_PWR_WAIT: begin
        dly_en = 1'b1;
        if (dly_zero) begin
          state_d   = S_CMD;
          cmd_idx_d = '0;
          tx_req_d  = 1'b1;
          tx_dc_d   = CTRL_CMD;
          tx_data_d = cmd_byte(5'd0);
          dly_load  = 1'b1;
        end
      end
      S_CMD, S_CLR, S_DISP_ON: begin
        dly_en = tx_req_q;
        if (!tx_req_q) begin
          tx_req_d  = 1'b1;
          tx_dc_d   = cur_dc;
          tx_data_d = cur_data;
          dly_load  = 1'b1;
        end else if (tx_done) begin
          tx_req_d = 1'b0;
          if (state_q == S_CMD) begin
            if (cmd_idx_q == CMD_LAST) begin
              state_d   = S_CLR;
              clr_cnt_d = '0;
            end else begin
              cmd_idx_d = cmd_idx_q + 5'd1;
            end
          end else if (state_q == S_CLR) begin
            if (clr_cnt_q == CLR_LAST) begin
              state_d = S_DISP_ON;
            end else begin
              clr_cnt_d = clr_cnt_q + 11'd1;
            end
          end else begin
            state_d = S_DONE;
          end
        end else if (dly_zero) begin
          tx_req_d = 1'b0;
          state_d  = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cmd_idx_q <= '0;
      clr_cnt_q <= '0;
      tx_req_q  <= 1'b0;
      tx_dc_q   <= 8'h00;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cmd_idx_q <= cmd_idx_d;
      clr_cnt_q <= clr_cnt_d;
      tx_req_q  <= tx_req_d;
      tx_dc_q   <= tx_dc_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_req  = tx_req_q;
  assign tx_dc   = tx_dc_q;
  assign tx_data = tx_data_q;
  assign busy    = (state_q != S_IDLE) &&
                   (state_q != S_DONE) &&
                   (state_q != S_ERROR);
  assign ready   = (state_q == S_DONE);
  assign err     = (state_q == S_ERROR);

endmodule

// File: tb/tb_oled_init_seq.sv
// Scoreboard bench for oled_init_seq.
// Default build plus a zero-delay, short-clear build.
module tb_oled_init_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       rst1, start1, tx_done1;
  logic       req1, busy1, ready1, err1;
  logic [7:0] dc1, data1;
  logic       rst2, start2, tx_done2;
  logic       req2, busy2, ready2, err2;
  logic [7:0] dc2, data2;

  oled_init_seq dut1 (
    .clk(clk), .rst(rst1), .start(start1),
    .tx_req(req1), .tx_dc(dc1), .tx_data(data1),
    .tx_done(tx_done1), .busy(busy1),
    .ready(ready1), .err(err1)
  );

  oled_init_seq #(
    .PWR_DELAY(0), .TIMEOUT(64), .CLR_BYTES(4)
  ) dut2 (
    .clk(clk), .rst(rst2), .start(start2),
    .tx_req(req2), .tx_dc(dc2), .tx_data(data2),
    .tx_done(tx_done2), .busy(busy2),
    .ready(ready2), .err(err2)
  );

  logic [7:0] cmd_tab [24] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3,
    8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00,
    8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
    8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6
  };

  logic [15:0] exp_q1 [$];
  logic [15:0] exp_q2 [$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic push_seq(input bit second,
                          input int nclr,
                          input int limit);
    logic [15:0] e [$];
    for (int i = 0; i < 24; i++) e.push_back({8'h00, cmd_tab[i]});
    for (int i = 0; i < nclr; i++) e.push_back(16'h4000);
    e.push_back(16'h00AF);
    for (int i = 0; i < e.size() && i < limit; i++) begin
      if (second) exp_q2.push_back(e[i]);
      else        exp_q1.push_back(e[i]);
    end
  endtask

  // Monitors: pop expected byte pair on each request rise.
  int txn1 = 0, rise1 = 0, fall1 = 0;
  logic [15:0] hold1;
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (req1 && !prev) begin
        txn1++;
        rise1 = cyc;
        hold1 = {dc1, data1};
        if (exp_q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m1_unexpected: got %0h expected none",
                   {dc1, data1});
        end else begin
          check("m1_txn", {16'h0, dc1, data1}, {16'h0, exp_q1.pop_front()});
        end
      end else if (req1 && prev) begin
        check("m1_stable", {16'h0, dc1, data1}, {16'h0, hold1});
      end
      if (!req1 && prev) fall1 = cyc;
      prev = req1;
    end
  end

  int txn2 = 0, rise2 = 0;
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (req2 && !prev) begin
        txn2++;
        rise2 = cyc;
        if (exp_q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m2_unexpected: got %0h expected none",
                   {dc2, data2});
        end else begin
          check("m2_txn", {16'h0, dc2, data2}, {16'h0, exp_q2.pop_front()});
        end
      end
      prev = req2;
    end
  end

  // Engine 1: tx_done 20 cycles after each rise, optional drop.
  int drop1 = -1;
  int eng1 = 0;
  initial begin
    logic prev;
    int cnt;
    prev = 1'b0;
    cnt = 0;
    tx_done1 = 1'b0;
    forever begin
      @(negedge clk);
      tx_done1 = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_done1 = 1'b1;
      end
      if (req1 && !prev) begin
        if (eng1 != drop1) cnt = 20;
        eng1++;
      end
      prev = req1;
    end
  end

  // Engine 2: double tx_done pulse, plus injected glitches.
  bit glitch2 = 1'b0;
  initial begin
    logic prev;
    int cnt;
    bit dbl;
    prev = 1'b0;
    cnt = 0;
    dbl = 1'b0;
    tx_done2 = 1'b0;
    forever begin
      @(negedge clk);
      tx_done2 = 1'b0;
      if (glitch2) begin
        tx_done2 = 1'b1;
        glitch2 = 1'b0;
      end else if (dbl) begin
        tx_done2 = 1'b1;
        dbl = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_done2 = 1'b1;
          dbl = 1'b1;
        end
      end
      if (req2 && !prev) cnt = 3;
      prev = req2;
    end
  end

  task automatic pulse_start1(output int s);
    start1 = 1'b1;
    s = cyc;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic reset1();
    rst1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
  endtask

  initial begin
    int s;
    rst1 = 1'b0; start1 = 1'b0;
    rst2 = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst1_outs", {26'h0, req1, busy1, ready1, err1, 2'b0}, 32'h0);
    check("rst1_bytes", {16'h0, dc1, data1}, 32'h0);
    check("rst2_outs", {28'h0, req2, busy2, ready2, err2}, 32'h0);
    rst1 = 1'b1; rst2 = 1'b1;
    @(negedge clk);

    // Full run at default parameters.
    push_seq(0, 1024, 2000);
    txn1 = 0; eng1 = 0;
    pulse_start1(s);
    check("pwr_wait_busy", {31'h0, busy1}, 32'h1);
    for (int i = 0; i < 2000 && txn1 == 0; i++) @(negedge clk);
    check("first_req_lat", rise1 - s, 1001);
    for (int i = 0; i < 40000 && !ready1; i++) @(negedge clk);
    check("full_ready", {29'h0, ready1, busy1, err1}, 32'h4);
    check("full_count", txn1, 1049);
    check("full_q_empty", exp_q1.size(), 0);

    // Timeout on the 5th transaction.
    drop1 = 4; eng1 = 0; txn1 = 0;
    push_seq(0, 1024, 5);
    pulse_start1(s);
    for (int i = 0; i < 10000 && !err1; i++) @(negedge clk);
    check("to_err", {29'h0, err1, busy1, req1}, 32'h4);
    check("to_len", fall1 - rise1, 4096);
    check("to_count", txn1, 5);
    drop1 = -1;
    pulse_start1(s);
    check("restart_err", {30'h0, err1, busy1}, 32'h1);
    reset1();

    // Reset while CLR byte 500 is outstanding.
    eng1 = 0; txn1 = 0;
    push_seq(0, 1024, 525);
    pulse_start1(s);
    for (int i = 0; i < 20000 && txn1 < 525; i++) @(negedge clk);
    check("clr500_reached", txn1, 525);
    repeat (5) @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", {26'h0, req1, busy1, ready1, err1, 2'b0}, 32'h0);
    check("mid_rst_bytes", {16'h0, dc1, data1}, 32'h0);
    rst1 = 1'b1;
    repeat (30) @(negedge clk);
    check("late_done_idle", {30'h0, req1, busy1}, 32'h0);
    txn1 = 0;
    push_seq(0, 1024, 3);
    pulse_start1(s);
    for (int i = 0; i < 2000 && txn1 < 3; i++) @(negedge clk);
    check("replay_count", txn1, 3);
    reset1();
    repeat (30) @(negedge clk);
    check("replay_q_empty", exp_q1.size(), 0);

    // Zero-delay build: glitches, double done, ignored start.
    glitch2 = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_glitch", {30'h0, req2, busy2}, 32'h0);
    push_seq(1, 4, 100);
    start2 = 1'b1;
    s = cyc;
    @(negedge clk);
    start2 = 1'b0;
    check("zero_dly_lat", rise2 - s, 1);
    for (int i = 0; i < 500 && txn2 < 10; i++) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("start_in_cmd", {31'h0, busy2}, 32'h1);
    for (int i = 0; i < 2000 && !ready2; i++) @(negedge clk);
    check("d2_ready", {29'h0, ready2, busy2, err2}, 32'h4);
    check("d2_count", txn2, 29);
    check("d2_q_empty", exp_q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
